zigzag_pingpong_buf: RTL

//  Zigzag reorder stage directly upstream of the run-length encoder.

---
 rtl/zigzag_pingpong_buf.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/zigzag_pingpong_buf.sv
// Zigzag reorder stage feeding the run-length encoder: raster rows in, zigzag groups out.
// Two banks alternate between writer and reader so consecutive blocks stream with no gap.
module zigzag_pingpong_buf #(
  parameter int COEF_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [8*COEF_W-1:0] in_row,
  output logic                out_valid,
  output logic [8*COEF_W-1:0] out_data,
  output logic                out_first,
  output logic                out_last
);

  localparam int ROW_W = 8 * COEF_W;

  // Zigzag position k -> raster index {row, col}.
  localparam logic [5:0] ZZ_MAP [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  logic [COEF_W-1:0] coef_mem [2][64];

  logic       wr_bank;
  logic [2:0] wr_row;
  logic       wr_accept;
  logic [1:0] full;
  logic [1:0] full_next;

  rd_state_t  state;
  rd_state_t  next_state;
  logic       rd_bank;
  logic       next_rd_bank;
  logic [2:0] rd_cnt;
  logic [2:0] next_rd_cnt;
  logic       rd_fire;
  logic       rd_done;
  logic [ROW_W-1:0] group_data;

  // A bank being released by the reader on this edge may be refilled on the same edge.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    full_next = full;
    wr_accept = in_valid && (!full[wr_bank] || (rd_done && (rd_bank == wr_bank)));
    if (rd_done) begin
      full_next[rd_bank] = 1'b0;
    end
    if (wr_accept && (wr_row == 3'd7)) begin
      full_next[wr_bank] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
      full    <= '0;
    end else begin
      full <= full_next;
      if (wr_accept) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // NOTE: the coefficient store is deliberately not reset; the full flags decide what is valid, and a reset would only cost a clear network.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      for (int c = 0; c < 8; c++) begin
        coef_mem[wr_bank][{wr_row, 3'(c)}] <= in_row[(7-c)*COEF_W +: COEF_W];
      end
    end
  end

  // Reader: rd_cnt is the group registered at the coming edge; it rests at 0 while IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state   <= next_state;
      rd_bank <= next_rd_bank;
      rd_cnt  <= next_rd_cnt;
    end
  end

  // Banks fill strictly alternately, so the oldest full bank is always the next one in turn.
  always_comb begin
    next_state   = state;
    next_rd_bank = rd_bank;
    next_rd_cnt  = rd_cnt;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          next_state  = READ;
          next_rd_cnt = 3'd1;
        end
      end
      READ: begin
        if (rd_cnt == 3'd7) begin
          next_rd_cnt  = 3'd0;
          next_rd_bank = ~rd_bank;
          if (!full[~rd_bank]) begin
            next_state = IDLE;
          end
        end else begin
          next_rd_cnt = rd_cnt + 3'd1;
        end
      end
    endcase
  end

  always_comb begin
    rd_fire = (state == READ) || full[rd_bank];
    rd_done = (state == READ) && (rd_cnt == 3'd7);
    for (int j = 0; j < 8; j++) begin
      group_data[(7-j)*COEF_W +: COEF_W] = coef_mem[rd_bank][ZZ_MAP[{rd_cnt, 3'(j)}]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rd_fire;
      out_first <= rd_fire && (rd_cnt == 3'd0);
      out_last  <= rd_done;
      if (rd_fire) begin
        out_data <= group_data;
      end
    end
  end

endmodule
